// File: rtl/data_chk_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : data_chk_fifo
//  Description : Drains a first-word-not-fall-through FIFO and checks every
//                word against the generator pattern k = 0..size-1, repeated
//                `times` passes. Reports the mismatch count and the first
//                failing word through an ap_ctrl start/ready/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_chk_fifo #(
   parameter int WIDTH = 32
) (
   input  logic             ap_clk,
   input  logic             ap_rst_n,
   input  logic [31:0]      size,
   input  logic [31:0]      times,
   output logic             fifo_rd_en,
   input  logic [WIDTH-1:0] fifo_rd_data,
   input  logic             fifo_empty,
   input  logic             ap_start,
   output logic             ap_ready,
   output logic             ap_done,
   output logic             ap_idle,
   output logic [31:0]      err_count,
   output logic [31:0]      first_err_idx,
   output logic [WIDTH-1:0] first_err_data,
   output logic             err_flag
);

   localparam logic [1:0] c_ST_IDLE = 2'd0;
   localparam logic [1:0] c_ST_READ = 2'd1;
   localparam logic [1:0] c_ST_DONE = 2'd2;

   logic [1:0]       r_state;
   logic [1:0]       w_next_state;

   // Run parameters captured when the start is accepted
   logic [31:0]      r_size;
   logic [31:0]      r_times;

   // Issue side: which word the next read strobe fetches
   logic [31:0]      r_iss_k;
   logic [31:0]      r_iss_pass;
   logic             r_iss_done;

   // Check side: which word the returning data is compared against
   logic             r_rd_valid;
   logic [31:0]      r_chk_k;
   logic [31:0]      r_chk_pass;
   logic [31:0]      r_chk_idx;

   logic [31:0]      r_err_count;
   logic [31:0]      r_first_err_idx;
   logic [WIDTH-1:0] r_first_err_data;
   logic             r_err_flag;

   logic             w_start;
   logic             w_cmp_last;
   logic             w_mismatch;
   logic [WIDTH-1:0] w_exp;

   assign w_start    = (r_state == c_ST_IDLE) && ap_start;
   assign w_cmp_last = r_rd_valid && (r_chk_pass == r_times - 32'd1)
                                  && (r_chk_k == r_size - 32'd1);
   assign w_mismatch = r_rd_valid && (fifo_rd_data != w_exp);

   // Expected word is the in-pass index, fitted to the data width
   generate
      if (WIDTH <= 32) begin : g_exp_trunc
         assign w_exp = r_chk_k[WIDTH-1:0];
      end else begin : g_exp_zext
         assign w_exp = {{(WIDTH-32){1'b0}}, r_chk_k};
      end
   endgenerate

   // State register
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) r_state <= c_ST_IDLE;
      else           r_state <= w_next_state;
   end

   // Next-state decode; an empty run skips straight to DONE
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_ST_IDLE: begin
            if (ap_start) begin
               if ((size == 32'd0) || (times == 32'd0)) w_next_state = c_ST_DONE;
               else                                     w_next_state = c_ST_READ;
            end
         end
         c_ST_READ: begin
            if (w_cmp_last) w_next_state = c_ST_DONE;
         end
         c_ST_DONE: w_next_state = c_ST_IDLE;
         default:   w_next_state = c_ST_IDLE;
      endcase
   end

   // Handshake and read-strobe decode
   always_comb begin
      ap_idle    = (r_state == c_ST_IDLE);
      ap_ready   = (r_state == c_ST_IDLE) && ap_start;
      ap_done    = (r_state == c_ST_DONE);
      fifo_rd_en = (r_state == c_ST_READ) && !fifo_empty && !r_iss_done;
   end

   // Latch run parameters on start acceptance only
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_size  <= '0;
         r_times <= '0;
      end else if (w_start) begin
         r_size  <= size;
         r_times <= times;
      end
   end

   // Issue counters: nested k/pass so the total never needs a wide product
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_iss_k    <= '0;
         r_iss_pass <= '0;
         r_iss_done <= 1'b0;
      end else if (w_start) begin
         r_iss_k    <= '0;
         r_iss_pass <= '0;
         r_iss_done <= 1'b0;
      end else if (fifo_rd_en) begin
         if (r_iss_k == r_size - 32'd1) begin
            r_iss_k <= '0;
            if (r_iss_pass == r_times - 32'd1) r_iss_done <= 1'b1;
            else                               r_iss_pass <= r_iss_pass + 32'd1;
         end else begin
            r_iss_k <= r_iss_k + 32'd1;
         end
      end
   end

   // Read data arrives one cycle after the strobe; check counters follow it
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_rd_valid <= 1'b0;
         r_chk_k    <= '0;
         r_chk_pass <= '0;
         r_chk_idx  <= '0;
      end else if (w_start) begin
         r_rd_valid <= 1'b0;
         r_chk_k    <= '0;
         r_chk_pass <= '0;
         r_chk_idx  <= '0;
      end else begin
         r_rd_valid <= fifo_rd_en;
         if (r_rd_valid) begin
            r_chk_idx <= r_chk_idx + 32'd1;
            if (r_chk_k == r_size - 32'd1) begin
               r_chk_k    <= '0;
               r_chk_pass <= r_chk_pass + 32'd1;
            end else begin
               r_chk_k <= r_chk_k + 32'd1;
            end
         end
      end
   end

   // Result capture: saturating count, first-failure snapshot
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_err_count      <= '0;
         r_first_err_idx  <= '0;
         r_first_err_data <= '0;
         r_err_flag       <= 1'b0;
      end else if (w_start) begin
         r_err_count      <= '0;
         r_first_err_idx  <= '0;
         r_first_err_data <= '0;
         r_err_flag       <= 1'b0;
      end else if (w_mismatch) begin
         if (r_err_count != 32'hFFFF_FFFF) r_err_count <= r_err_count + 32'd1;
         if (!r_err_flag) begin
            r_first_err_idx  <= r_chk_idx;
            r_first_err_data <= fifo_rd_data;
            r_err_flag       <= 1'b1;
         end
      end
   end

   assign err_count      = r_err_count;
   assign first_err_idx  = r_first_err_idx;
   assign first_err_data = r_first_err_data;
   assign err_flag       = r_err_flag;

endmodule
`default_nettype wire

// File: tb/tb_data_chk_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_data_chk_fifo
//  Description : Self-checking bench for data_chk_fifo (32-bit and 8-bit
//                instances) with a behavioural FIFO and result model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_chk_fifo;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int passed = 0;

   logic [31:0] size_i = '0, times_i = '0;
   logic        start32 = 1'b0, start8 = 1'b0, force_empty = 1'b0, flush = 1'b0;
   bit          sel_g = 1'b0;

   // 32-bit instance
   logic        rd_en32, ready32, done32, idle32, flag32, empty32;
   logic [31:0] ec32, fei32, fed32;
   logic [31:0] rdata32 = '0;
   logic [31:0] mem32 [0:1023];
   logic [31:0] wr_ptr32 = '0, rd_ptr32 = '0;

   // 8-bit instance
   logic        rd_en8, ready8, done8, idle8, flag8, empty8;
   logic [31:0] ec8, fei8;
   logic [7:0]  fed8;
   logic [7:0]  rdata8 = '0;
   logic [7:0]  mem8 [0:1023];
   logic [31:0] wr_ptr8 = '0, rd_ptr8 = '0;

   assign empty32 = force_empty || (wr_ptr32 == rd_ptr32);
   assign empty8  = force_empty || (wr_ptr8 == rd_ptr8);

   data_chk_fifo #(.WIDTH(32)) u_dut32 (
      .ap_clk(clk), .ap_rst_n(rst_n), .size(size_i), .times(times_i),
      .fifo_rd_en(rd_en32), .fifo_rd_data(rdata32), .fifo_empty(empty32),
      .ap_start(start32), .ap_ready(ready32), .ap_done(done32), .ap_idle(idle32),
      .err_count(ec32), .first_err_idx(fei32), .first_err_data(fed32), .err_flag(flag32)
   );

   data_chk_fifo #(.WIDTH(8)) u_dut8 (
      .ap_clk(clk), .ap_rst_n(rst_n), .size(size_i), .times(times_i),
      .fifo_rd_en(rd_en8), .fifo_rd_data(rdata8), .fifo_empty(empty8),
      .ap_start(start8), .ap_ready(ready8), .ap_done(done8), .ap_idle(idle8),
      .err_count(ec8), .first_err_idx(fei8), .first_err_data(fed8), .err_flag(flag8)
   );

   // FIFO model: FWFT-off, data valid the cycle after an accepted read
   always @(posedge clk) begin
      if (!rst_n || flush) begin
         rd_ptr32 <= wr_ptr32;
         rd_ptr8  <= wr_ptr8;
      end else begin
         if (rd_en32 && (rd_ptr32 != wr_ptr32)) begin
            rdata32  <= mem32[rd_ptr32[9:0]];
            rd_ptr32 <= rd_ptr32 + 1;
         end
         if (rd_en8 && (rd_ptr8 != wr_ptr8)) begin
            rdata8  <= mem8[rd_ptr8[9:0]];
            rd_ptr8 <= rd_ptr8 + 1;
         end
      end
   end

   // Views of whichever instance the current scenario drives
   logic        m_rd_en, m_ready, m_done, m_idle, m_flag, m_empty;
   logic [31:0] m_ec, m_fei, m_fed;
   assign m_rd_en = sel_g ? rd_en8  : rd_en32;
   assign m_ready = sel_g ? ready8  : ready32;
   assign m_done  = sel_g ? done8   : done32;
   assign m_idle  = sel_g ? idle8   : idle32;
   assign m_flag  = sel_g ? flag8   : flag32;
   assign m_empty = sel_g ? empty8  : empty32;
   assign m_ec    = sel_g ? ec8     : ec32;
   assign m_fei   = sel_g ? fei8    : fei32;
   assign m_fed   = sel_g ? {24'd0, fed8} : fed32;

   logic [31:0] wq [$];

   task automatic load_fifo(input bit sel, input int n);
      logic [31:0] v;
      for (int i = 0; i < n + 3; i++) begin
         v = (i < n) ? wq[i] : $urandom;
         if (sel) begin mem8[wr_ptr8[9:0]] = v[7:0]; wr_ptr8 = wr_ptr8 + 1; end
         else     begin mem32[wr_ptr32[9:0]] = v;    wr_ptr32 = wr_ptr32 + 1; end
      end
   endtask

   task automatic set_start(input bit sel, input logic val);
      if (sel) start8 = val; else start32 = val;
   endtask

   task automatic do_run(input bit sel, input logic [31:0] sz, input logic [31:0] tm,
                         input int stall_after, input int stall_len, input bit hold_start,
                         input string name);
      int n, rd_cnt, viol, ready_cnt, done_cyc, exp_done, exp_err, c0, stall_left;
      logic [31:0] wmask, exp_idx, exp_data, left;
      bit got;
      sel_g = sel;
      wmask = sel ? 32'h0000_00FF : 32'hFFFF_FFFF;
      n = (sz == 0 || tm == 0) ? 0 : int'(sz * tm);
      exp_err = 0; exp_idx = '0; exp_data = '0; got = 1'b0;
      for (int i = 0; i < n; i++) begin
         if ((wq[i] & wmask) != ((i % sz) & wmask)) begin
            if (!got) begin got = 1'b1; exp_idx = i; exp_data = wq[i] & wmask; end
            exp_err++;
         end
      end
      exp_done = (n == 0) ? 1 : n + 2 + stall_len;

      @(negedge clk);
      load_fifo(sel, n);
      force_empty = 1'b0;
      size_i = sz; times_i = tm;
      set_start(sel, 1'b1);
      #1;
      c0 = cyc; rd_cnt = 0; viol = 0; done_cyc = -1; stall_left = stall_len;
      checks++;
      if (m_ready !== 1'b1) $display("FAIL %s ready_at_start: got %b want 1", name, m_ready);
      else passed++;
      ready_cnt = m_ready ? 1 : 0;
      if (m_rd_en) viol++;

      while (done_cyc < 0 && (cyc - c0) < 2000) begin
         @(negedge clk);
         if (!hold_start) set_start(sel, 1'b0);
         size_i = $urandom; times_i = $urandom;
         if (stall_left > 0 && rd_cnt >= stall_after) begin
            force_empty = 1'b1; stall_left--;
         end else force_empty = 1'b0;
         #1;
         if (m_rd_en) begin rd_cnt++; if (m_empty) viol++; end
         if (m_ready) ready_cnt++;
         if (m_done) begin done_cyc = cyc - c0; set_start(sel, 1'b0); end
      end
      set_start(sel, 1'b0);
      force_empty = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      left = sel ? (wr_ptr8 - rd_ptr8) : (wr_ptr32 - rd_ptr32);

      checks++;
      if (done_cyc != exp_done) $display("FAIL %s done_cycle: got %0d want %0d", name, done_cyc, exp_done);
      else passed++;
      checks++;
      if (rd_cnt != n) $display("FAIL %s reads: got %0d want %0d", name, rd_cnt, n);
      else passed++;
      checks++;
      if (viol != 0) $display("FAIL %s rd_en_while_empty: got %0d want 0", name, viol);
      else passed++;
      checks++;
      if (ready_cnt != 1) $display("FAIL %s ready_pulses: got %0d want 1", name, ready_cnt);
      else passed++;
      checks++;
      if (left != 32'd3) $display("FAIL %s words_left: got %0d want 3", name, left);
      else passed++;
      checks++;
      if (m_ec !== exp_err) $display("FAIL %s err_count: got %0d want %0d", name, m_ec, exp_err);
      else passed++;
      checks++;
      if (m_flag !== (exp_err > 0)) $display("FAIL %s err_flag: got %b want %b", name, m_flag, exp_err > 0);
      else passed++;
      checks++;
      if (m_fei !== exp_idx) $display("FAIL %s first_err_idx: got %0d want %0d", name, m_fei, exp_idx);
      else passed++;
      checks++;
      if (m_fed !== exp_data) $display("FAIL %s first_err_data: got %0d want %0d", name, m_fed, exp_data);
      else passed++;
      checks++;
      if (m_idle !== 1'b1) $display("FAIL %s idle_after: got %b want 1", name, m_idle);
      else passed++;

      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
   endtask

   task automatic fill_pattern(input int sz, input int tm);
      wq.delete();
      for (int i = 0; i < sz * tm; i++) wq.push_back(i % sz);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({rd_en32, ready32, done32, idle32, flag32} !== 5'b00010)
         $display("FAIL reset32_ctrl: got %b want 00010", {rd_en32, ready32, done32, idle32, flag32});
      else passed++;
      checks++;
      if ({ec32, fei32, fed32} !== 96'd0) $display("FAIL reset32_results: got %h want 0", {ec32, fei32, fed32});
      else passed++;
      checks++;
      if ({rd_en8, ready8, done8, idle8, flag8, ec8, fei8, fed8} !== {5'b00010, 72'd0})
         $display("FAIL reset8: got %h want %h", {rd_en8, ready8, done8, idle8, flag8, ec8, fei8, fed8},
                  {5'b00010, 72'd0});
      else passed++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_clean();
      fill_pattern(4, 2);
      do_run(1'b0, 32'd4, 32'd2, 0, 0, 1'b0, "clean");
   endtask

   task automatic test_corrupt();
      fill_pattern(8, 1);
      wq[5] = 32'd99;
      do_run(1'b0, 32'd8, 32'd1, 0, 0, 1'b0, "corrupt1");
      wq[7] = 32'd1234;
      do_run(1'b0, 32'd8, 32'd1, 0, 0, 1'b0, "corrupt2");
   endtask

   task automatic test_backpressure();
      fill_pattern(6, 1);
      do_run(1'b0, 32'd6, 32'd1, 3, 10, 1'b0, "backpressure");
   endtask

   task automatic test_degenerate();
      wq.delete();
      do_run(1'b0, 32'd0, 32'd5, 0, 0, 1'b0, "size0");
      do_run(1'b0, 32'd3, 32'd0, 0, 0, 1'b0, "times0");
   endtask

   task automatic test_wrap_width();
      wq.delete();
      for (int i = 0; i < 300; i++) wq.push_back(i % 256);
      do_run(1'b1, 32'd300, 32'd1, 0, 0, 1'b0, "wrap8");
   endtask

   task automatic test_hold_start();
      fill_pattern(5, 2);
      wq[6] = 32'hDEAD_BEEF;
      do_run(1'b0, 32'd5, 32'd2, 0, 0, 1'b1, "hold_start");
   endtask

   task automatic test_reset_midrun();
      sel_g = 1'b0;
      fill_pattern(16, 1);
      wq[1] = 32'd77;
      @(negedge clk);
      load_fifo(1'b0, 16);
      size_i = 32'd16; times_i = 32'd1; start32 = 1'b1;
      @(negedge clk);
      start32 = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      checks++;
      if (flag32 !== 1'b1) $display("FAIL midrun_flag_before_reset: got %b want 1", flag32);
      else passed++;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({rd_en32, ready32, done32, idle32, flag32} !== 5'b00010)
         $display("FAIL midrun_reset_ctrl: got %b want 00010", {rd_en32, ready32, done32, idle32, flag32});
      else passed++;
      checks++;
      if ({ec32, fei32, fed32} !== 96'd0) $display("FAIL midrun_reset_results: got %h want 0", {ec32, fei32, fed32});
      else passed++;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      fill_pattern(3, 3);
      do_run(1'b0, 32'd3, 32'd3, 0, 0, 1'b0, "after_reset");
   endtask

   task automatic test_random();
      bit          sel;
      logic [31:0] sz, tm, v;
      int          n, sa, sl;
      for (int it = 0; it < 10; it++) begin
         sel = 1'($urandom_range(0, 1));
         sz  = $urandom_range(1, 12);
         tm  = $urandom_range(1, 3);
         n   = int'(sz * tm);
         wq.delete();
         for (int i = 0; i < n; i++) begin
            v = i % sz;
            if ($urandom_range(0, 4) == 0) v = $urandom;
            wq.push_back(v);
         end
         sa = $urandom_range(0, n - 1);
         sl = $urandom_range(0, 6);
         do_run(sel, sz, tm, sa, sl, 1'($urandom_range(0, 1)), "random");
      end
   endtask

   initial begin
      test_reset();
      test_clean();
      test_corrupt();
      test_backpressure();
      test_degenerate();
      test_wrap_width();
      test_hold_start();
      test_reset_midrun();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
`default_nettype wire
